// File: rtl/mcycle.sv
// -----------------------------------------------------------------------------
// mcycle -- iterative multi-cycle multiply / divide unit
//
// Unsigned shift-add multiply (2*WIDTH product) and restoring divide
// (quotient + remainder), one bit per clock. The controller pulses Start and
// stalls until Done.
//
// Parameters
//   WIDTH     operand width (>= 4); also the iteration count per operation
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   Start     request; accepted only in IDLE or DONE
//   MCycleOp  0 = multiply, 1 = divide (latched with Start)
//   Operand1  multiplicand / dividend (latched with Start)
//   Operand2  multiplier / divisor (latched with Start)
//   Result1   MUL: product[WIDTH-1:0],       DIV: quotient
//   Result2   MUL: product[2*WIDTH-1:WIDTH], DIV: remainder
//   Busy      high while an operation iterates
//   Done      one-cycle pulse when results become valid
//
// Build option
//   MCYCLE_EARLY_DONE_EN  when defined, a multiply finishes as soon as the
//                         remaining multiplier bits are all zero (>= 1
//                         iteration). Division always takes WIDTH iterations.
// -----------------------------------------------------------------------------
module mcycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);

  // Encoding chosen so Busy and Done are the state register bits themselves.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               op;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  logic               accept;
  logic               div_by_zero;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic               unused_bits;

  assign Busy = state[0];
  assign Done = state[1];

  assign accept      = Start && ((state == IDLE) || (state == DONE));
  assign div_by_zero = MCycleOp && (Operand2 == '0);

  // One iteration of each algorithm, computed combinationally so the final
  // iteration can be written straight into the result registers.
  always_comb begin
    acc_nxt    = acc + (mplier[0] ? mcand_sh : '0);
    mplier_nxt = mplier >> 1;
    // Dividend bits enter the partial remainder MSB first from quo's top.
    rem_sh     = {rem, quo[WIDTH-1]};
    diff       = {1'b0, rem_sh} - {2'b00, divisor};
    qbit       = ~diff[WIDTH+1];
    // After a successful subtract the remainder is below the divisor, so
    // the low WIDTH bits hold it exactly.
    rem_nxt    = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt    = {quo[WIDTH-2:0], qbit};
    last_iter  = (cnt == CNT_W'(WIDTH - 1));
`ifdef MCYCLE_EARLY_DONE_EN
    if (!op && (mplier_nxt == '0)) begin
      last_iter = 1'b1;
    end
`endif
  end

  assign unused_bits = diff[WIDTH];

  // Control: state, iteration counter and the architecturally visible results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            cnt <= '0;
            if (div_by_zero) begin
              state   <= DONE;
              Result1 <= '1;
              Result2 <= Operand1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last_iter) begin
            state   <= DONE;
            Result1 <= op ? quo_nxt : acc_nxt[WIDTH-1:0];
            Result2 <= op ? rem_nxt : acc_nxt[2*WIDTH-1:WIDTH];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operands load on an accepted Start and iterate while in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= MCycleOp;
      acc      <= '0;
      mcand_sh <= {{WIDTH{1'b0}}, Operand1};
      mplier   <= Operand2;
      divisor  <= Operand2;
      rem      <= '0;
      quo      <= Operand1;
    end else if (state == RUN) begin
      acc      <= acc_nxt;
      mcand_sh <= mcand_sh << 1;
      mplier   <= mplier_nxt;
      rem      <= rem_nxt;
      quo      <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_mcycle.sv
module tb_mcycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int n_checks = 0;
  int n_fail   = 0;

  // Results the unit should currently be holding.
  logic [W-1:0] held1 = '0;
  logic [W-1:0] held2 = '0;

  // Back-to-back support: the next op is driven during the Done cycle.
  bit           chain_en = 1'b0;
  bit           chain_op;
  logic [W-1:0] chain_a;
  logic [W-1:0] chain_b;
  bit           pending = 1'b0;

  always #5 clk = ~clk;

  mcycle #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  // Number of Busy cycles an operation should take.
  function automatic int exp_len(input bit op, input logic [W-1:0] b);
    if (op) return (b == '0) ? 0 : W;
`ifdef MCYCLE_EARLY_DONE_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
`else
    return W;
`endif
  endfunction

  task automatic run_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    logic [2*W-1:0] p;
    logic [W-1:0]   e1;
    logic [W-1:0]   e2;
    int             len;
    int             bad_b;
    int             bad_d;
    int             bad_r;
    int             done_j;
    int             last_j;
    if (op) begin
      if (b == '0) begin
        e1 = '1;
        e2 = a;
      end else begin
        e1 = a / b;
        e2 = a % b;
      end
    end else begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e1 = p[W-1:0];
      e2 = p[2*W-1:W];
    end
    len = exp_len(op, b);
    if (!pending) begin
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      Start    = 1'b1;
    end
    pending = 1'b0;
    @(posedge clk);
    bad_b  = 0;
    bad_d  = 0;
    bad_r  = 0;
    done_j = 0;
    last_j = chain_en ? len + 1 : W + 3;
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      if (j == 1 || j == inj + 1) begin
        Start    = 1'b0;
        MCycleOp = 1'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
      if (Busy !== (j <= len)) bad_b++;
      if (Done !== (j == len + 1)) bad_d++;
      if (Done === 1'b1 && done_j == 0) done_j = j;
      if (j <= len) begin
        if (Result1 !== held1 || Result2 !== held2) bad_r++;
      end else begin
        if (Result1 !== e1 || Result2 !== e2) bad_r++;
      end
      if (j == inj) begin
        Start    = 1'b1;
        MCycleOp = 1'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
    end
    check($sformatf("busy_pattern op%0d %0h,%0h", op, a, b), 64'(bad_b), 64'(0));
    check($sformatf("done_pattern op%0d %0h,%0h", op, a, b), 64'(bad_d), 64'(0));
    check($sformatf("done_cycle op%0d %0h,%0h", op, a, b), 64'(done_j), 64'(len + 1));
    check($sformatf("result1 op%0d %0h,%0h", op, a, b), 64'(Result1), 64'(e1));
    check($sformatf("result2 op%0d %0h,%0h", op, a, b), 64'(Result2), 64'(e2));
    check($sformatf("result_hold op%0d %0h,%0h", op, a, b), 64'(bad_r), 64'(0));
    held1 = e1;
    held2 = e2;
    if (chain_en) begin
      chain_en = 1'b0;
      MCycleOp = chain_op;
      Operand1 = chain_a;
      Operand2 = chain_b;
      Start    = 1'b1;
      pending  = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit           cur_op;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    bit           nxt_op;
    logic [W-1:0] nxt_a;
    logic [W-1:0] nxt_b;
    int           done_seen;

    reset    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(Busy), 64'(0));
    check("reset_done", 64'(Done), 64'(0));
    check("reset_r1", 64'(Result1), 64'(0));
    check("reset_r2", 64'(Result2), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(Busy), 64'(0));

    // Directed operations
    run_op(1'b0, 32'd7, 32'd6, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(1'b1, 32'd100, 32'd7, -1);
    run_op(1'b1, 32'd5, 32'd0, -1);
    run_op(1'b0, 32'd0, 32'd0, -1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, -1);
    run_op(1'b1, 32'd3, 32'hFFFF_FFFF, -1);
    // Start during RUN is ignored
    run_op(1'b1, 32'd123456, 32'd789, 5);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h8000_0001, 5);
    // Back-to-back: new Start during the Done cycle
    chain_en = 1'b1; chain_op = 1'b1; chain_a = 32'd1000; chain_b = 32'd7;
    run_op(1'b0, 32'd12345, 32'd678, -1);
    chain_en = 1'b1; chain_op = 1'b1; chain_a = 32'd77; chain_b = 32'd0;
    run_op(1'b1, 32'd1000, 32'd7, -1);
    chain_en = 1'b1; chain_op = 1'b0; chain_a = 32'd9; chain_b = 32'd11;
    run_op(1'b1, 32'd77, 32'd0, -1);
    run_op(1'b0, 32'd9, 32'd11, -1);

    // Reset in the middle of a divide
    MCycleOp = 1'b1;
    Operand1 = 32'd100000;
    Operand2 = 32'd3;
    Start    = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    check("busy_before_reset", 64'(Busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(Busy), 64'(0));
    check("midrst_done", 64'(Done), 64'(0));
    check("midrst_r1", 64'(Result1), 64'(0));
    check("midrst_r2", 64'(Result2), 64'(0));
    done_seen = 0;
    for (int j = 0; j < W + 8; j++) begin
      @(negedge clk);
      if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
    end
    check("no_activity_after_reset", 64'(done_seen), 64'(0));
    held1 = '0;
    held2 = '0;
    run_op(1'b0, 32'd3, 32'd3, -1);

    // Randomized operations, some chained back-to-back
    nxt_op = 1'($urandom);
    nxt_a  = $urandom;
    nxt_b  = $urandom;
    for (int i = 0; i < 24; i++) begin
      cur_op = nxt_op;
      cur_a  = nxt_a;
      cur_b  = nxt_b;
      nxt_op = 1'($urandom);
      nxt_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       nxt_b = '0;
        1:       nxt_b = W'($urandom_range(1, 255));
        2:       nxt_b = $urandom;
        default: nxt_b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i < 23 && $urandom_range(0, 2) == 0) begin
        chain_en = 1'b1;
        chain_op = nxt_op;
        chain_a  = nxt_a;
        chain_b  = nxt_b;
      end
      run_op(cur_op, cur_a, cur_b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
